uart_block_rx: RTL and testbench
================================

# uart_block_rx

Receive-side companion to the design's UART transmit path. Deserialises 8N1 UART bytes from a single serial input and assembles `BYTES` consecutive bytes into one block, such as a 128-bit AES plaintext or key. It then presents the block with a one-cycle valid strobe. It sits between the board's RX pin and the AES core's block inputs.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Must be ≥ 4.
- `BYTES`, default 16: bytes per block.
- `TIMEOUT_BITS`, default 32: idle bit-times after which a partial block is discarded.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: **asynchronous, active-low** reset.
- `uart_rx`  in  1: serial input, idle high; asynchronous to `clk`.
- `o_block`  out  8*BYTES: last complete block; first received byte in bits [8*BYTES-1 -: 8].
- `o_valid`  out  1: one-cycle pulse when `o_block` updates.
- `o_frame_err`  out  1: one-cycle pulse on a bad stop bit.
- `o_busy`  out  1: high while any byte of a block is in flight or buffered.

## Operation
- **Input synchroniser.** `uart_rx` passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised signal `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE.**
  - A falling edge of `rx_s` loads the bit counter with 0 and moves to START.
  - While in IDLE with a partial block buffered, the idle counter increments.
- **START.**
  - After CLKS_PER_BIT/2 cycles (integer division), sample `rx_s`.
  - If 0, go to DATA.
  - If 1, it is a false start: return to IDLE with no error and no byte.
- **DATA.** 8 samples spaced CLKS_PER_BIT apart, LSB first, shifted into the byte register. After bit 7, go to STOP.
- **STOP.** Sample CLKS_PER_BIT after bit 7.
  - **Sample = 1:** the byte is accepted.
    - It is shifted into the block buffer; older bytes move toward the MSB end.
    - The byte count increments.
    - If the count reaches BYTES, `o_block` ← buffer, `o_valid` pulses, and the count returns to 0.
    - Then go to IDLE.
  - **Sample = 0:** frame error.
    - `o_frame_err` pulses.
    - The byte and any partial block are discarded; the count returns to 0.
    - Then go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` = 1, then go to IDLE. This prevents a break condition from being treated as a stream of start bits.
- **Inter-byte timeout.**
  - If the count ≠ 0 and the FSM stays in IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles, the count clears silently.
  - The idle counter resets on any start edge.
- **`o_busy`** = (state ≠ IDLE) or (count ≠ 0).
- **`o_block`** changes only on a completed block. It holds its value through errors, timeouts and partial blocks.

## Timing
- **Reset values:**
  - `o_block` = 0, `o_valid` = 0, `o_frame_err` = 0, `o_busy` = 0.
  - State IDLE, all counters 0, synchroniser flops 1.
- **Reset mid-byte or mid-block:** all state is cleared immediately. Nothing is emitted. After reset releases, reception starts cleanly at the next falling edge.
- **Sample points:** the start sample is ≈CLKS_PER_BIT/2 + 2 cycles after the pin edge (synchroniser delay included). Each later sample is exactly CLKS_PER_BIT after the previous one.
- **`o_valid` latency:** `o_valid` is high for exactly one cycle. It is registered on the same edge as the stop sample of byte BYTES. `o_block` is valid in that cycle and afterwards.
- **`o_frame_err`:** registered on the stop-sample edge, one cycle wide.
- **Back-to-back bytes** (a start bit immediately after a stop bit) are accepted; the falling edge is detected in IDLE following STOP.
- **Byte-count wrap:** the count runs 0..BYTES-1 and never reaches BYTES as a stored value. The next byte after a completed block starts a new block.
- **Timeout vs. start bit on the same cycle:** the start edge wins; the byte counts toward the current block.

## Test plan
- **Nominal block.** After reset, send 16 bytes 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34 back-to-back.
  - One `o_valid` pulse.
  - `o_block` = 128'h3243f6a8885a308d313198a2e0370734.
  - `o_busy` = 0 afterwards.
- **Two blocks.** Send the nominal block, then the 16 bytes of 2b7e151628aed2a6abf7158809cf4f3c.
  - Two `o_valid` pulses.
  - Final `o_block` = 128'h2b7e151628aed2a6abf7158809cf4f3c.
- **Frame error.** Send 5 bytes, then 0x55 with stop bit 0, then the nominal 16 bytes.
  - One `o_frame_err` pulse.
  - No `o_valid` until the 16th later byte.
  - `o_block` = nominal value.
- **False start.** Apply a 0 glitch of CLKS_PER_BIT/4 cycles on an idle line.
  - No state change beyond START.
  - No `o_frame_err`, no `o_valid`.
  - The count stays 0.
- **Timeout.** Send 7 bytes, hold the line idle for TIMEOUT_BITS+1 bit-times, then send the nominal 16 bytes.
  - Exactly one `o_valid`.
  - `o_block` = nominal value.
- **Async reset.** Assert `rst_n` = 0 mid-bit during the 10th byte, release it, then send the nominal block.
  - All outputs are 0 during reset.
  - Exactly one `o_valid` with the nominal value.

Source files
------------

// File: rtl/uart_block_rx.sv
// 8N1 UART receiver that assembles BYTES consecutive bytes into one block.
// A frame error drops the partial block; a long idle gap silently drops it.
module uart_block_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int BYTES        = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    output logic [8*BYTES-1:0] o_block,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int CW        = $clog2(CLKS_PER_BIT);
    localparam int BW        = $clog2(BYTES + 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IW        = $clog2(TO_CYCLES + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TO_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic               sync1_r, sync2_r, rx_prev_r;
    logic               rx_s, start_edge_s;
    logic [2:0]         state_r, state_nxt_s;
    logic [CW-1:0]      clk_cnt_r, clk_cnt_nxt_s;
    logic [2:0]         bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]         shift_r, shift_nxt_s;
    logic [BW-1:0]      byte_cnt_r, byte_cnt_nxt_s;
    logic [IW-1:0]      idle_cnt_r, idle_cnt_nxt_s;
    logic [8*BYTES-1:0] buf_r, buf_nxt_s, buf_shift_s;
    logic [8*BYTES-1:0] block_nxt_s;
    logic               valid_nxt_s, ferr_nxt_s, busy_nxt_s;

    assign rx_s         = sync2_r;
    assign start_edge_s = rx_prev_r & ~rx_s;
    assign buf_shift_s  = {buf_r[8*BYTES-9:0], shift_r};

    // Next-state logic for the receive FSM, counters and block buffer.
    always_comb begin
        state_nxt_s    = state_r;
        clk_cnt_nxt_s  = clk_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        byte_cnt_nxt_s = byte_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        buf_nxt_s      = buf_r;
        block_nxt_s    = o_block;
        valid_nxt_s    = 1'b0;
        ferr_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A start edge beats a timeout landing on the same cycle.
                if (start_edge_s) begin
                    state_nxt_s    = ST_START;
                    clk_cnt_nxt_s  = {CW{1'b0}};
                    bit_cnt_nxt_s  = 3'd0;
                    idle_cnt_nxt_s = {IW{1'b0}};
                end else if (byte_cnt_r != {BW{1'b0}}) begin
                    if (idle_cnt_r == IDLE_LAST) begin
                        byte_cnt_nxt_s = {BW{1'b0}};
                        idle_cnt_nxt_s = {IW{1'b0}};
                    end else begin
                        idle_cnt_nxt_s = idle_cnt_r + 1'b1;
                    end
                end else begin
                    idle_cnt_nxt_s = {IW{1'b0}};
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_nxt_s = {CW{1'b0}};
                    state_nxt_s   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nxt_s = {CW{1'b0}};
                    shift_nxt_s   = {rx_s, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nxt_s = {CW{1'b0}};
                    if (rx_s) begin
                        buf_nxt_s   = buf_shift_s;
                        state_nxt_s = ST_IDLE;
                        if (byte_cnt_r == BYTE_LAST) begin
                            block_nxt_s    = buf_shift_s;
                            valid_nxt_s    = 1'b1;
                            byte_cnt_nxt_s = {BW{1'b0}};
                        end else begin
                            byte_cnt_nxt_s = byte_cnt_r + 1'b1;
                        end
                    end else begin
                        ferr_nxt_s     = 1'b1;
                        byte_cnt_nxt_s = {BW{1'b0}};
                        state_nxt_s    = ST_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                byte_cnt_nxt_s = {BW{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE) || (byte_cnt_nxt_s != {BW{1'b0}});
    end

    // Input synchroniser, edge-detect history and all registered state/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            rx_prev_r   <= 1'b1;
            state_r     <= ST_IDLE;
            clk_cnt_r   <= {CW{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            byte_cnt_r  <= {BW{1'b0}};
            idle_cnt_r  <= {IW{1'b0}};
            buf_r       <= {(8*BYTES){1'b0}};
            o_block     <= {(8*BYTES){1'b0}};
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            sync1_r     <= uart_rx;
            sync2_r     <= sync1_r;
            rx_prev_r   <= rx_s;
            state_r     <= state_nxt_s;
            clk_cnt_r   <= clk_cnt_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            byte_cnt_r  <= byte_cnt_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
            buf_r       <= buf_nxt_s;
            o_block     <= block_nxt_s;
            o_valid     <= valid_nxt_s;
            o_frame_err <= ferr_nxt_s;
            o_busy      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_block_rx.sv
// Self-checking bench for uart_block_rx: directed scenarios plus random blocks,
// checked against a byte-queue model of block assembly.
module tb_uart_block_rx;

    localparam int CPB   = 16;
    localparam int NB    = 16;
    localparam int TOB   = 32;

    logic         clk;
    logic         rst_n;
    logic         uart_rx;
    logic [127:0] o_block;
    logic         o_valid;
    logic         o_frame_err;
    logic         o_busy;

    uart_block_rx #(.CLKS_PER_BIT(CPB), .BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .o_block(o_block), .o_valid(o_valid),
        .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    // Model state
    logic [7:0]   mq[$];
    logic [127:0] exp_block = 128'h0;
    int           exp_valid = 0;
    int           exp_ferr  = 0;
    int           idle_bits = 0;

    // Observed pulses
    int           act_valid = 0;
    int           act_ferr  = 0;

    logic [127:0] nom;
    logic [127:0] key;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) act_valid++;
            if (o_frame_err) act_ferr++;
        end
    end

    function automatic logic [127:0] pack_queue();
        logic [127:0] r = 128'h0;
        foreach (mq[i]) r = {r[119:0], mq[i]};
        return r;
    endfunction

    task automatic drive_bit(input logic b, input int cycles);
        uart_rx = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop_bit, CPB);
        idle_bits = 0;
        if (stop_bit) begin
            mq.push_back(d);
            if (mq.size() == NB) begin
                exp_block = pack_queue();
                exp_valid++;
                mq.delete();
            end
        end else begin
            exp_ferr++;
            mq.delete();
        end
    endtask

    task automatic idle(input int nbits);
        drive_bit(1'b1, nbits * CPB);
        idle_bits += nbits;
        if (idle_bits > TOB) mq.delete();
    endtask

    task automatic send_block(input logic [127:0] b, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(b[127-8*i -: 8], 1'b1);
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        check({tag, "_valid_cnt"}, 128'(act_valid), 128'(exp_valid));
        check({tag, "_ferr_cnt"}, 128'(act_ferr), 128'(exp_ferr));
        check({tag, "_block"}, o_block, exp_block);
        check({tag, "_busy"}, {127'h0, o_busy}, {127'h0, mq.size() != 0});
    endtask

    initial begin
        nom = 128'h3243f6a8885a308d313198a2e0370734;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_block, o_valid, o_frame_err, o_busy} , 131'h0);
        rst_n = 1'b1;
        idle(2);

        // Nominal block
        send_block(nom, 0, NB - 1);
        checkpoint("nominal");
        idle(1);
        check("nominal_busy_after", {127'h0, o_busy}, 128'h0);

        // Two blocks back to back
        send_block(nom, 0, NB - 1);
        send_block(key, 0, NB - 1);
        checkpoint("two_blocks");

        // Frame error then a full block
        send_block(key, 0, 4);
        send_byte(8'h55, 1'b0);
        idle(2);
        checkpoint("ferr_after");
        send_block(nom, 0, NB - 2);
        checkpoint("ferr_mid");
        send_block(nom, NB - 1, NB - 1);
        checkpoint("ferr_done");

        // False start glitch
        drive_bit(1'b0, CPB / 4);
        drive_bit(1'b1, 2);
        check("false_start_busy", {127'h0, o_busy}, 128'h1);
        idle(2);
        checkpoint("false_start");

        // Inter-byte timeout
        send_block(key, 0, 6);
        idle(1);
        checkpoint("timeout_partial");
        idle(TOB);
        checkpoint("timeout_cleared");
        send_block(nom, 0, NB - 1);
        checkpoint("timeout_block");

        // Async reset during the 10th byte
        send_block(key, 0, 8);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(key[127-8*9-i], CPB);
        drive_bit(key[127-8*9-4], CPB / 2);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {o_block, o_valid, o_frame_err, o_busy}, 131'h0);
        mq.delete();
        exp_block = 128'h0;
        drive_bit(1'b1, 4);
        rst_n = 1'b1;
        idle(2);
        checkpoint("post_reset");
        send_block(nom, 0, NB - 1);
        checkpoint("reset_block");

        // Random blocks with occasional frame errors and short gaps
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    send_byte(8'($urandom), 1'b0);
                    idle(2);
                end
                send_byte(8'($urandom), 1'b1);
                idle($urandom_range(0, 2));
            end
            checkpoint("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
